// File: rtl/stack_controller_pkg.sv
// Shared definitions for the stack controller: default sizing and FSM state encoding.
package stack_controller_pkg;

  localparam int DEF_DATA_W = 32;    // width of a stacked word
  localparam int DEF_DEPTH  = 1024;  // number of stack entries
  localparam int DEF_SP_W   = 32;    // stack pointer / memory address width

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_ADDR,
    S_POP_CAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/stack_controller_if.sv
// Request/status bus between the control unit and the stack controller.
//   master : control unit side (drives push_req/pop_req/push_data, reads status)
//   slave  : stack controller side
interface stack_controller_if #(
  parameter int DATA_W = 32,
  parameter int SP_W   = 32
);
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pop_data;
  logic [SP_W-1:0]   sp;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push_req, pop_req, push_data,
    input  busy, done, pop_data, sp, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  push_req, pop_req, push_data,
    output busy, done, pop_data, sp, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/stack_controller.sv
// Stack controller: owns the stack pointer and sequences push/pop accesses to
// the stack memory. Push takes 2 cycles to done, pop 3, error cases 1.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_if (slave)    : requests from the control unit, status back
//   mem_sp_o          : stack memory address (registered)
//   mem_push_o        : memory write strobe (registered)
//   mem_pop_o         : memory read strobe (registered)
//   mem_data_in_o     : memory write data (registered)
//   mem_data_out_i    : memory read data
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SP_W   = DEF_SP_W
) (
  input  logic              clk,
  input  logic              reset,
  stack_controller_if.slave req_if,
  output logic [SP_W-1:0]   mem_sp_o,
  output logic              mem_push_o,
  output logic              mem_pop_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i
);

  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [SP_W-1:0]   mem_sp_q, mem_sp_d;
  logic              mem_push_q, mem_push_d;
  logic              mem_pop_q, mem_pop_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic full, empty;
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    mem_sp_d    = mem_sp_q;
    mem_push_d  = 1'b0;
    mem_pop_d   = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        // push has priority; a simultaneous pop is dropped
        if (req_if.push_req) begin
          if (full) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            mem_sp_d    = sp_q;
            mem_wdata_d = req_if.push_data;
            mem_push_d  = 1'b1;
            state_d     = S_PUSH;
          end
        end else if (req_if.pop_req) begin
          if (empty) begin
            unf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            // sp drops on entry so the address already points at the top word
            sp_d      = sp_q - SP_W'(1);
            mem_sp_d  = sp_q - SP_W'(1);
            mem_pop_d = 1'b1;
            state_d   = S_POP_ADDR;
          end
        end
      end
      S_PUSH: begin
        sp_d    = sp_q + SP_W'(1);
        state_d = S_DONE;
      end
      S_POP_ADDR: begin
        // keep the read strobe up for the capture cycle
        mem_pop_d = 1'b1;
        state_d   = S_POP_CAP;
      end
      S_POP_CAP: begin
        pop_data_d = mem_data_out_i;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      pop_data_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      mem_sp_q    <= '0;
      mem_push_q  <= 1'b0;
      mem_pop_q   <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      mem_sp_q    <= mem_sp_d;
      mem_push_q  <= mem_push_d;
      mem_pop_q   <= mem_pop_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_if.busy          = (state_q != S_IDLE);
  assign req_if.done          = (state_q == S_DONE);
  assign req_if.pop_data      = pop_data_q;
  assign req_if.sp            = sp_q;
  assign req_if.full          = full;
  assign req_if.empty         = empty;
  assign req_if.overflow_err  = ovf_q;
  assign req_if.underflow_err = unf_q;

  assign mem_sp_o      = mem_sp_q;
  assign mem_push_o    = mem_push_q;
  assign mem_pop_o     = mem_pop_q;
  assign mem_data_in_o = mem_wdata_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed table, hand-written corner sequences and a
// randomized phase checked against a queue-based stack model.
module tb_stack_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_controller_if #(.DATA_W(32), .SP_W(32)) bus();

  logic [31:0] mem_sp, mem_wdata, mem_rdata;
  logic        mem_push, mem_pop;

  stack_controller #(.DATA_W(32), .DEPTH(1024), .SP_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_if        (bus.slave),
    .mem_sp_o      (mem_sp),
    .mem_push_o    (mem_push),
    .mem_pop_o     (mem_pop),
    .mem_data_in_o (mem_wdata),
    .mem_data_out_i(mem_rdata)
  );

  // 1024x32 stack memory with registered read
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_push) mem[mem_sp[9:0]] <= mem_wdata;
    if (mem_pop)  mem_rdata <= mem[mem_sp[9:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and observe it until done (bounded).
  task automatic run_req(input bit p, input bit q, input logic [31:0] d, input bit noise,
                         output int lat, output int np, output int nq,
                         output logic [31:0] addr, output logic [31:0] wd,
                         output bit both, output bit busy_after, output bit done_after);
    @(negedge clk);
    bus.push_req = p; bus.pop_req = q; bus.push_data = d;
    lat = -1; np = 0; nq = 0; addr = '0; wd = '0; both = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_push) begin np++; addr = mem_sp; wd = mem_wdata; end
      if (mem_pop) begin if (nq == 0) addr = mem_sp; nq++; end
      if (mem_push && mem_pop) both = 1'b1;
      if (bus.done) begin lat = k; break; end
      if (noise) begin
        {bus.push_req, bus.pop_req} = 2'($urandom_range(0, 3));
        bus.push_data = $urandom;
      end else begin
        bus.push_req = 1'b0; bus.pop_req = 1'b0;
      end
    end
    bus.push_req = 1'b0; bus.pop_req = 1'b0;
    @(negedge clk);
    busy_after = bus.busy;
    done_after = bus.done;
  endtask

  typedef struct {
    bit p, q, noise;
    logic [31:0] d;
    int lat, np, nq;
    logic [31:0] addr, sp, pop;
    bit ovf, unf;
  } vec_t;

  vec_t tbl[12];

  int lat, np, nq;
  logic [31:0] addr, wd;
  bit both, busy_after, done_after;

  task automatic apply_reset();
    bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //            p  q  nz data          lat np nq addr sp pop          ovf unf
    tbl[0]  = '{1, 0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 1, 32'h0,        0, 0};
    tbl[1]  = '{0, 1, 0, 32'h0,        3, 0, 2, 0, 0, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{1, 0, 0, 32'hA5A5A5A5, 2, 1, 0, 0, 1, 32'hDEADBEEF, 0, 0};
    tbl[3]  = '{1, 0, 0, 32'h12345678, 2, 1, 0, 1, 2, 32'hDEADBEEF, 0, 0};
    tbl[4]  = '{0, 1, 0, 32'h0,        3, 0, 2, 1, 1, 32'h12345678, 0, 0};
    tbl[5]  = '{0, 1, 0, 32'h0,        3, 0, 2, 0, 0, 32'hA5A5A5A5, 0, 0};
    tbl[6]  = '{0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 1};
    tbl[7]  = '{0, 1, 1, 32'h0,        1, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 1};
    tbl[8]  = '{1, 0, 0, 32'h00000001, 2, 1, 0, 0, 1, 32'hA5A5A5A5, 0, 1};
    tbl[9]  = '{1, 0, 0, 32'h00000002, 2, 1, 0, 1, 2, 32'hA5A5A5A5, 0, 1};
    tbl[10] = '{1, 0, 0, 32'h00000003, 2, 1, 0, 2, 3, 32'hA5A5A5A5, 0, 1};
    tbl[11] = '{1, 1, 1, 32'h00000004, 2, 1, 0, 3, 4, 32'hA5A5A5A5, 0, 1};

    // ---- reset state ----
    reset = 1'b1;
    bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sp", bus.sp, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    chk("rst_unf", bus.underflow_err, 0);
    chk("rst_mem_push", mem_push, 0);
    chk("rst_mem_pop", mem_pop, 0);
    chk("rst_mem_sp", mem_sp, 0);
    chk("rst_pop_data", bus.pop_data, 0);
    reset = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].p, tbl[i].q, tbl[i].d, tbl[i].noise,
              lat, np, nq, addr, wd, both, busy_after, done_after);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_npush", i), np, tbl[i].np);
      chk($sformatf("tbl%0d_npop", i), nq, tbl[i].nq);
      if (tbl[i].np + tbl[i].nq > 0) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
      if (tbl[i].np > 0) chk($sformatf("tbl%0d_wdata", i), wd, tbl[i].d);
      chk($sformatf("tbl%0d_sp", i), bus.sp, tbl[i].sp);
      chk($sformatf("tbl%0d_pop_data", i), bus.pop_data, tbl[i].pop);
      chk($sformatf("tbl%0d_ovf", i), bus.overflow_err, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), bus.underflow_err, tbl[i].unf);
      chk($sformatf("tbl%0d_empty", i), bus.empty, tbl[i].sp == 0);
      chk($sformatf("tbl%0d_both_strobes", i), both, 0);
      chk($sformatf("tbl%0d_busy_after", i), busy_after, 0);
      chk($sformatf("tbl%0d_done_width", i), done_after, 0);
    end

    // ---- reset while in POP_CAP (sp = 4 here) ----
    @(negedge clk);
    bus.pop_req = 1'b1;
    @(negedge clk);            // POP_ADDR
    bus.pop_req = 1'b0;
    @(negedge clk);            // POP_CAP
    chk("abort_in_cap_mem_pop", mem_pop, 1);
    chk("abort_in_cap_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_pop", mem_pop, 0);
    chk("abort_sp", bus.sp, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_unf_cleared", bus.underflow_err, 0);
    reset = 1'b0;
    begin
      bit seen = 1'b0;
      repeat (4) begin @(negedge clk); if (bus.done) seen = 1'b1; end
      chk("abort_no_done", seen, 0);
    end

    // ---- fill to full, then overflow ----
    begin
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
        run_req(1, 0, 32'h1000_0000 + i, 0, lat, np, nq, addr, wd, both, busy_after, done_after);
        if (lat != 2 || addr != i || np != 1) bad++;
      end
      chk("fill_bad_pushes", bad, 0);
    end
    chk("fill_sp", bus.sp, 1024);
    chk("fill_full", bus.full, 1);
    chk("fill_empty", bus.empty, 0);
    chk("fill_ovf_clear", bus.overflow_err, 0);
    run_req(1, 0, 32'hFFFF_FFFF, 0, lat, np, nq, addr, wd, both, busy_after, done_after);
    chk("ovf_lat", lat, 1);
    chk("ovf_npush", np, 0);
    chk("ovf_err", bus.overflow_err, 1);
    chk("ovf_sp", bus.sp, 1024);
    chk("ovf_full", bus.full, 1);
    run_req(0, 1, 32'h0, 0, lat, np, nq, addr, wd, both, busy_after, done_after);
    chk("top_pop_data", bus.pop_data, 32'h1000_0000 + 1023);
    chk("top_pop_addr", addr, 1023);
    chk("top_pop_sp", bus.sp, 1023);
    chk("top_pop_full", bus.full, 0);
    chk("ovf_sticky", bus.overflow_err, 1);

    // ---- randomized phase against a queue model ----
    apply_reset();
    begin
      logic [31:0] model[$];
      logic [31:0] last_pop = '0;
      bit m_ovf = 1'b0, m_unf = 1'b0;
      for (int n = 0; n < 400; n++) begin
        int r = $urandom_range(0, 9);
        bit p = (r < 4) || (r == 9);
        bit q = (r >= 4);
        logic [31:0] d = $urandom;
        int e_lat, e_np, e_nq;
        logic [31:0] e_addr = '0;
        if (p) begin
          if (model.size() == 1024) begin
            e_lat = 1; e_np = 0; e_nq = 0; m_ovf = 1'b1;
          end else begin
            e_lat = 2; e_np = 1; e_nq = 0; e_addr = model.size();
            model.push_back(d);
          end
        end else if (model.size() == 0) begin
          e_lat = 1; e_np = 0; e_nq = 0; m_unf = 1'b1;
        end else begin
          e_lat = 3; e_np = 0; e_nq = 2; e_addr = model.size() - 1;
          last_pop = model.pop_back();
        end
        run_req(p, q, d, 1'($urandom_range(0, 1)), lat, np, nq, addr, wd, both, busy_after, done_after);
        chk($sformatf("rnd%0d_lat", n), lat, e_lat);
        chk($sformatf("rnd%0d_npush", n), np, e_np);
        chk($sformatf("rnd%0d_npop", n), nq, e_nq);
        if (e_np + e_nq > 0) chk($sformatf("rnd%0d_addr", n), addr, e_addr);
        chk($sformatf("rnd%0d_sp", n), bus.sp, model.size());
        chk($sformatf("rnd%0d_pop_data", n), bus.pop_data, last_pop);
        chk($sformatf("rnd%0d_ovf", n), bus.overflow_err, m_ovf);
        chk($sformatf("rnd%0d_unf", n), bus.underflow_err, m_unf);
        chk($sformatf("rnd%0d_empty", n), bus.empty, model.size() == 0);
        chk($sformatf("rnd%0d_both", n), both, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
